// File: rtl/p405s_timer_wd_fit_gen.sv
// p405s_timer_wd_fit_gen
//   Watchdog / fixed-interval-timer event engine for the timer unit, clocked by CB.
//   For each FIT channel and for the watchdog it selects one time-base tap and turns
//   that tap's rising edge into a one-cycle event. It also keeps the sticky per-channel
//   FIT status, runs the ENW/WIS watchdog state machine, and produces stretched
//   core/chip/system reset requests.
// Ports
//   CB, resetCoreN        clock and asynchronous active-low reset
//   fitTaps/fitTapSel     candidate time-base bits and tap select for each FIT channel
//   fitStatusClr          software clear of the sticky FIT status, one bit per channel
//   wdTaps/wdTapSel       candidate time-base bits and tap select for the watchdog
//   wdRstType             reset type launched from INTR (00 none, 01 core, 10 chip, 11 sys)
//   wdEnwClr/wdWisClr     software clears of ENW and WIS
//   hwSetFitStatus        FIT event pulse; fitStatus is the sticky copy
//   wdPulse               watchdog tap event pulse
//   wdEnw/wdWis           TSR ENW and WIS
//   hwSetWdIntrp          pulse when hardware sets WIS
//   hwSetWdRst            pulse when a reset is launched
//   wdRstStatus           reset type captured at launch (TSR WRS)
//   TIM_wd*Rst            stretched reset requests
module p405s_timer_wd_fit_gen #(
  parameter int FIT_CH   = 2,
  parameter int SEL_W    = 2,
  parameter int RST_CYC  = 16,
  parameter int RSTCNT_W = 5
) (
  input  logic                          CB,
  input  logic                          resetCoreN,
  input  logic [FIT_CH*(2**SEL_W)-1:0]  fitTaps,
  input  logic [FIT_CH*SEL_W-1:0]       fitTapSel,
  input  logic [FIT_CH-1:0]             fitStatusClr,
  input  logic [(2**SEL_W)-1:0]         wdTaps,
  input  logic [SEL_W-1:0]              wdTapSel,
  input  logic [1:0]                    wdRstType,
  input  logic                          wdEnwClr,
  input  logic                          wdWisClr,
  output logic [FIT_CH-1:0]             hwSetFitStatus,
  output logic [FIT_CH-1:0]             fitStatus,
  output logic                          wdPulse,
  output logic                          wdEnw,
  output logic                          wdWis,
  output logic                          hwSetWdIntrp,
  output logic                          hwSetWdRst,
  output logic [1:0]                    wdRstStatus,
  output logic                          TIM_wdCoreRst,
  output logic                          TIM_wdChipRst,
  output logic                          TIM_wdSysRst
);

  localparam int NTAPS = 2**SEL_W;

  // Watchdog phase: RUN covers IDLE/ARMED/INTR (held in ENW/WIS), RESET is the stretch.
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_RESET = 1'b1;

  logic [FIT_CH-1:0]       fitSelT;
  logic [FIT_CH-1:0]       fitEvent;
  logic [FIT_CH-1:0]       fitTapDly;
  logic [FIT_CH*SEL_W-1:0] fitSelDly;
  logic [NTAPS-1:0]        chTaps;

  logic                    wdSelT;
  logic                    wdEvent;
  logic                    wdTapDly;
  logic [SEL_W-1:0]        wdSelDly;

  logic [0:0]              wdState;
  logic [RSTCNT_W-1:0]     rstCnt;
  logic                    enwPostClr;
  logic                    wisPostClr;
  logic                    reqActive;

  // Stage 0: tap select and edge detect. A select change this cycle masks the
  // event so a TCR write cannot produce a spurious pulse.
  always_comb begin
    fitSelT  = '0;
    fitEvent = '0;
    chTaps   = '0;
    for (int c = 0; c < FIT_CH; c++) begin
      chTaps      = fitTaps[c*NTAPS +: NTAPS];
      fitSelT[c]  = chTaps[fitTapSel[c*SEL_W +: SEL_W]];
      fitEvent[c] = fitSelT[c] & ~fitTapDly[c] &
                    (fitTapSel[c*SEL_W +: SEL_W] == fitSelDly[c*SEL_W +: SEL_W]);
    end
    wdSelT  = wdTaps[wdTapSel];
    wdEvent = wdSelT & ~wdTapDly & (wdTapSel == wdSelDly);
  end

  // Software clears act first; a watchdog pulse then works on the cleared values.
  assign enwPostClr = wdEnw & ~wdEnwClr;
  assign wisPostClr = wdWis & ~wdWisClr;
  assign reqActive  = (wdState == ST_RESET) && (rstCnt != '0);

  // Stage 1: registered events, sticky status and watchdog state.
  always_ff @(posedge CB or negedge resetCoreN) begin
    if (!resetCoreN) begin
      fitTapDly      <= '0;
      fitSelDly      <= '0;
      hwSetFitStatus <= '0;
      fitStatus      <= '0;
      wdTapDly       <= 1'b0;
      wdSelDly       <= '0;
      wdPulse        <= 1'b0;
      wdState        <= ST_RUN;
      wdEnw          <= 1'b0;
      wdWis          <= 1'b0;
      hwSetWdIntrp   <= 1'b0;
      hwSetWdRst     <= 1'b0;
      wdRstStatus    <= 2'b00;
      rstCnt         <= '0;
      TIM_wdCoreRst  <= 1'b0;
      TIM_wdChipRst  <= 1'b0;
      TIM_wdSysRst   <= 1'b0;
    end else begin
      fitTapDly      <= fitSelT;
      fitSelDly      <= fitTapSel;
      hwSetFitStatus <= fitEvent;
      // set beats clear when both land in the same cycle
      fitStatus      <= (fitStatus & ~fitStatusClr) | fitEvent;

      wdTapDly       <= wdSelT;
      wdSelDly       <= wdTapSel;
      wdPulse        <= wdEvent;

      hwSetWdIntrp   <= 1'b0;
      hwSetWdRst     <= 1'b0;

      if (wdState == ST_RESET) begin
        // pulses and software clears are ignored while the request is stretched
        if (rstCnt != '0) begin
          rstCnt <= rstCnt - 1'b1;
        end else begin
          wdState <= ST_RUN;
          wdEnw   <= 1'b0;
          wdWis   <= 1'b0;
        end
      end else if (wdPulse) begin
        if (!enwPostClr) begin
          wdEnw <= 1'b1;
          wdWis <= wisPostClr;
        end else if (!wisPostClr) begin
          wdEnw        <= 1'b1;
          wdWis        <= 1'b1;
          hwSetWdIntrp <= 1'b1;
        end else if (wdRstType != 2'b00) begin
          wdState     <= ST_RESET;
          hwSetWdRst  <= 1'b1;
          wdRstStatus <= wdRstType;
          rstCnt      <= RSTCNT_W'(RST_CYC);
        end
      end else begin
        wdEnw <= enwPostClr;
        wdWis <= wisPostClr;
      end

      // request is high on the RST_CYC cycles following hwSetWdRst
      TIM_wdCoreRst <= reqActive && (wdRstStatus == 2'b01);
      TIM_wdChipRst <= reqActive && (wdRstStatus == 2'b10);
      TIM_wdSysRst  <= reqActive && (wdRstStatus == 2'b11);
    end
  end

endmodule

// File: tb/tb_p405s_timer_wd_fit_gen.sv
module tb_p405s_timer_wd_fit_gen;

  localparam int FIT_CH = 2;
  localparam int SEL_W  = 2;
  localparam int NTAPS  = 4;

  logic                      CB = 1'b0;
  logic                      resetCoreN;
  logic [FIT_CH*NTAPS-1:0]   fitTaps;
  logic [FIT_CH*SEL_W-1:0]   fitTapSel;
  logic [FIT_CH-1:0]         fitStatusClr;
  logic [NTAPS-1:0]          wdTaps;
  logic [SEL_W-1:0]          wdTapSel;
  logic [1:0]                wdRstType;
  logic                      wdEnwClr;
  logic                      wdWisClr;
  logic [FIT_CH-1:0]         hwSetFitStatus;
  logic [FIT_CH-1:0]         fitStatus;
  logic                      wdPulse;
  logic                      wdEnw;
  logic                      wdWis;
  logic                      hwSetWdIntrp;
  logic                      hwSetWdRst;
  logic [1:0]                wdRstStatus;
  logic                      TIM_wdCoreRst;
  logic                      TIM_wdChipRst;
  logic                      TIM_wdSysRst;

  int total = 0;
  int bad   = 0;

  p405s_timer_wd_fit_gen #(
    .FIT_CH(FIT_CH), .SEL_W(SEL_W), .RST_CYC(16), .RSTCNT_W(5)
  ) dut (
    .CB(CB), .resetCoreN(resetCoreN),
    .fitTaps(fitTaps), .fitTapSel(fitTapSel), .fitStatusClr(fitStatusClr),
    .wdTaps(wdTaps), .wdTapSel(wdTapSel), .wdRstType(wdRstType),
    .wdEnwClr(wdEnwClr), .wdWisClr(wdWisClr),
    .hwSetFitStatus(hwSetFitStatus), .fitStatus(fitStatus),
    .wdPulse(wdPulse), .wdEnw(wdEnw), .wdWis(wdWis),
    .hwSetWdIntrp(hwSetWdIntrp), .hwSetWdRst(hwSetWdRst), .wdRstStatus(wdRstStatus),
    .TIM_wdCoreRst(TIM_wdCoreRst), .TIM_wdChipRst(TIM_wdChipRst), .TIM_wdSysRst(TIM_wdSysRst)
  );

  always #5 CB = ~CB;

  task automatic tick();
    @(posedge CB);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {core, chip, sys}
  function automatic logic [2:0] rstReqs();
    return {TIM_wdCoreRst, TIM_wdChipRst, TIM_wdSysRst};
  endfunction

  // One rising edge on watchdog tap 0; returns after the FSM has reacted to wdPulse.
  task automatic wdRise(input logic wisClr, input string tag);
    wdTaps = 4'b0001;
    tick();
    chk({tag, "_wdPulse"}, wdPulse, 1'b1);
    wdTaps   = 4'b0000;
    wdWisClr = wisClr;
    tick();
    wdWisClr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    resetCoreN   = 1'b0;
    fitTaps      = '0;
    fitTapSel    = '0;
    fitStatusClr = '0;
    wdTaps       = '0;
    wdTapSel     = '0;
    wdRstType    = 2'b10;
    wdEnwClr     = 1'b0;
    wdWisClr     = 1'b0;
    tick();
    tick();
    chk("rst_fitStatus", fitStatus, 2'b00);
    chk("rst_hwSetFit", hwSetFitStatus, 2'b00);
    chk("rst_enw_wis", {wdEnw, wdWis}, 2'b00);
    chk("rst_wrs", wdRstStatus, 2'b00);
    chk("rst_reqs", rstReqs(), 3'b000);
    resetCoreN = 1'b1;

    // FIT channel 0 on tap 1, channel 1 on tap 0
    fitTapSel = {2'd0, 2'd1};
    tick();
    tick();
    chk("fit_idle", hwSetFitStatus, 2'b00);
    fitTaps = 8'b0000_0010;
    tick();
    chk("fit_pulse", hwSetFitStatus, 2'b01);
    chk("fit_status", fitStatus, 2'b01);
    tick();
    chk("fit_pulse_once", hwSetFitStatus, 2'b00);
    chk("fit_sticky", fitStatus, 2'b01);
    fitStatusClr = 2'b01;
    tick();
    fitStatusClr = 2'b00;
    chk("fit_clear", fitStatus, 2'b00);

    // select change onto an already-high tap must not fire
    fitTaps = 8'b0000_0100;
    tick();
    chk("sel_pre", hwSetFitStatus, 2'b00);
    fitTapSel = {2'd0, 2'd2};
    tick();
    chk("sel_change_nopulse", hwSetFitStatus, 2'b00);
    tick();
    chk("sel_after_nopulse", hwSetFitStatus, 2'b00);
    chk("sel_status", fitStatus, 2'b00);

    // channel 1 set and clear in the same cycle: set wins
    fitTaps      = 8'b0001_0100;
    fitStatusClr = 2'b10;
    tick();
    fitStatusClr = 2'b00;
    chk("setwins_pulse", hwSetFitStatus, 2'b10);
    chk("setwins_status", fitStatus, 2'b10);

    // watchdog: chip reset sequence
    wdRstType = 2'b10;
    wdRise(1'b0, "e1");
    chk("e1_enw_wis", {wdEnw, wdWis}, 2'b10);
    chk("e1_intrp", hwSetWdIntrp, 1'b0);
    wdRise(1'b0, "e2");
    chk("e2_enw_wis", {wdEnw, wdWis}, 2'b11);
    chk("e2_intrp", hwSetWdIntrp, 1'b1);
    tick();
    chk("e2_intrp_once", hwSetWdIntrp, 1'b0);
    wdRise(1'b0, "e3");
    chk("e3_hwSetWdRst", hwSetWdRst, 1'b1);
    chk("e3_wrs", wdRstStatus, 2'b10);
    chk("e3_req_not_yet", rstReqs(), 3'b000);
    for (int i = 1; i <= 16; i++) begin
      if (i == 3) wdTaps = 4'b0001;
      if (i == 4) wdTaps = 4'b0000;
      tick();
      chk($sformatf("chip_stretch%0d", i), rstReqs(), 3'b010);
      if (i == 1) chk("e3_hwSetWdRst_once", hwSetWdRst, 1'b0);
    end
    tick();
    chk("chip_end_req", rstReqs(), 3'b000);
    chk("chip_end_enw_wis", {wdEnw, wdWis}, 2'b00);
    chk("chip_end_wrs", wdRstStatus, 2'b10);

    // back to INTR, then WIS clear coinciding with the pulse
    wdRise(1'b0, "f1");
    chk("f1_enw_wis", {wdEnw, wdWis}, 2'b10);
    wdRise(1'b0, "f2");
    chk("f2_enw_wis", {wdEnw, wdWis}, 2'b11);
    wdRise(1'b1, "f3");
    chk("wisclr_enw_wis", {wdEnw, wdWis}, 2'b11);
    chk("wisclr_intrp", hwSetWdIntrp, 1'b1);
    chk("wisclr_no_launch", hwSetWdRst, 1'b0);
    tick();
    chk("wisclr_no_req", rstReqs(), 3'b000);

    // reset type none: pulses in INTR change nothing
    wdRstType = 2'b00;
    wdRise(1'b0, "n1");
    chk("none1_state", {wdEnw, wdWis, hwSetWdRst}, 3'b110);
    wdRise(1'b0, "n2");
    chk("none2_state", {wdEnw, wdWis, hwSetWdRst}, 3'b110);
    tick();
    chk("none_reqs", rstReqs(), 3'b000);

    // system reset, aborted by resetCoreN mid-stretch
    wdRstType = 2'b11;
    wdRise(1'b0, "s1");
    chk("sys_hwSetWdRst", hwSetWdRst, 1'b1);
    chk("sys_wrs", wdRstStatus, 2'b11);
    for (int i = 1; i <= 5; i++) tick();
    chk("sys_stretch5", rstReqs(), 3'b001);
    #3;
    resetCoreN = 1'b0;
    #1;
    chk("abort_async_sys", TIM_wdSysRst, 1'b0);
    chk("abort_wrs", wdRstStatus, 2'b00);
    tick();
    resetCoreN = 1'b1;
    fitTaps    = '0;
    tick();
    chk("post_reqs", rstReqs(), 3'b000);
    chk("post_enw_wis", {wdEnw, wdWis}, 2'b00);
    chk("post_pulses", {hwSetWdIntrp, hwSetWdRst, wdPulse}, 3'b000);
    chk("post_fit", {fitStatus, hwSetFitStatus}, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
